// File: rtl/hdmi_pixel_fifo.sv
// Pixel FIFO between the PLB master burst-read path and hdmi_core; empty reads return a fixed colour.
// Optional UNDERFLOW_CNT_EN macro adds a saturating 16-bit empty-read counter.
module hdmi_pixel_fifo #(
  parameter int                  C_DWIDTH          = 32,
  parameter int                  C_AWIDTH          = 8,
  parameter int                  C_HALF_LEVEL      = 128,
  parameter logic [C_DWIDTH-1:0] C_UNDERFLOW_COLOR = '0
) (
  input  logic                Bus2IP_Clk,
  input  logic                Bus2IP_Reset,
  input  logic                flush,
  input  logic                clr_status,
  input  logic                wr_en,
  input  logic [C_DWIDTH-1:0] wr_data,
  input  logic                rd_en,
  output logic [C_DWIDTH-1:0] rd_data,
  output logic                full,
  output logic                empty,
  output logic                half_full,
  output logic [C_AWIDTH:0]   level,
  output logic                overflow,
  output logic                underflow,
  output logic [15:0]         underflow_cnt
);

  localparam int               DEPTH      = 2 ** C_AWIDTH;
  localparam logic [C_AWIDTH:0]   FULL_LEVEL = (C_AWIDTH + 1)'(DEPTH);
  localparam logic [C_AWIDTH:0]   HALF_LEVEL = (C_AWIDTH + 1)'(C_HALF_LEVEL);
  localparam logic [C_AWIDTH:0]   LVL_ONE    = 1;
  localparam logic [C_AWIDTH-1:0] PTR_ONE    = 1;

  logic [C_DWIDTH-1:0] mem [0:DEPTH-1];
  logic [C_AWIDTH-1:0] wr_ptr;
  logic [C_AWIDTH-1:0] rd_ptr;
  logic                wr_accept;
  logic                rd_accept;
  logic                ovf_event;
  logic                udf_event;

  assign full      = (level == FULL_LEVEL);
  assign empty     = (level == '0);
  assign half_full = (level <= HALF_LEVEL);

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign wr_accept = !flush && wr_en && (!full || rd_en);
  assign rd_accept = !flush && rd_en && !empty;
  assign ovf_event = !flush && wr_en && full && !rd_en;
  assign udf_event = !flush && rd_en && empty;

  always_ff @(posedge Bus2IP_Clk) begin
    if (!Bus2IP_Reset && wr_accept)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_data   <= C_UNDERFLOW_COLOR;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (wr_accept)
          wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_accept)
          rd_ptr <= rd_ptr + PTR_ONE;
        if (wr_accept && !rd_accept)
          level <= level + LVL_ONE;
        else if (rd_accept && !wr_accept)
          level <= level - LVL_ONE;
      end

      if (rd_accept)
        rd_data <= mem[rd_ptr];
      else if (udf_event)
        rd_data <= C_UNDERFLOW_COLOR;

      // Error events in the same cycle as clr_status keep the flag set.
      overflow  <= ovf_event || (overflow && !clr_status);
      underflow <= udf_event || (underflow && !clr_status);
    end
  end

`ifdef UNDERFLOW_CNT_EN
  logic [15:0] udf_cnt;

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset)
      udf_cnt <= '0;
    else if (clr_status)
      udf_cnt <= {15'b0, udf_event};
    else if (udf_event && udf_cnt != 16'hFFFF)
      udf_cnt <= udf_cnt + 16'd1;
  end

  assign underflow_cnt = udf_cnt;
`else
  assign underflow_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hdmi_pixel_fifo.sv
// Self-checking bench for hdmi_pixel_fifo: vector table plus directed fill/drain, wrap, flush and reset sequences.
module tb_hdmi_pixel_fifo;

  logic        Bus2IP_Clk = 1'b0;
  logic        Bus2IP_Reset;
  logic        flush;
  logic        clr_status;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        full;
  logic        empty;
  logic        half_full;
  logic [8:0]  level;
  logic        overflow;
  logic        underflow;
  logic [15:0] underflow_cnt;

  int total_checks  = 0;
  int passed_checks = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        fl;
    logic        clr;
    logic [31:0] wdata;
    logic [31:0] exp_rd_data;
    logic [8:0]  exp_level;
    logic        exp_ovf;
    logic        exp_udf;
  } vec_t;

  vec_t vecs [16];

  hdmi_pixel_fifo dut (
    .Bus2IP_Clk    (Bus2IP_Clk),
    .Bus2IP_Reset  (Bus2IP_Reset),
    .flush         (flush),
    .clr_status    (clr_status),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .full          (full),
    .empty         (empty),
    .half_full     (half_full),
    .level         (level),
    .overflow      (overflow),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  always #5 Bus2IP_Clk = ~Bus2IP_Clk;

  task automatic applyStimulus(input logic rd, input logic wr, input logic fl,
                               input logic clr, input logic [31:0] wd);
    rd_en      = rd;
    wr_en      = wr;
    flush      = fl;
    clr_status = clr;
    wr_data    = wd;
    @(posedge Bus2IP_Clk);
    #1;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    flush      = 1'b0;
    clr_status = 1'b0;
    wr_data    = '0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual === expected)
      passed_checks++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  initial begin
    Bus2IP_Reset = 1'b1;
    flush = 0; clr_status = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    repeat (2) @(posedge Bus2IP_Clk);
    #1;
    Bus2IP_Reset = 1'b0;

    checkOutput("reset full",      32'(full),          32'd0);
    checkOutput("reset empty",     32'(empty),         32'd1);
    checkOutput("reset half_full", 32'(half_full),     32'd1);
    checkOutput("reset level",     32'(level),         32'd0);
    checkOutput("reset rd_data",   rd_data,            32'h0);
    checkOutput("reset overflow",  32'(overflow),      32'd0);
    checkOutput("reset underflow", 32'(underflow),     32'd0);
    checkOutput("reset udf_cnt",   32'(underflow_cnt), 32'd0);

    // rd wr fl clr wdata | rd_data level ovf udf
    vecs[0]  = '{0, 1, 0, 0, 32'h11, 32'h00, 9'd1, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 32'h22, 32'h00, 9'd2, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 32'h00, 32'h11, 9'd1, 0, 0};
    vecs[3]  = '{1, 1, 0, 0, 32'h33, 32'h22, 9'd1, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 32'h00, 32'h33, 9'd0, 0, 0};
    vecs[5]  = '{1, 0, 0, 0, 32'h00, 32'h00, 9'd0, 0, 1};
    vecs[6]  = '{0, 0, 0, 1, 32'h00, 32'h00, 9'd0, 0, 0};
    vecs[7]  = '{1, 1, 0, 0, 32'hAA, 32'h00, 9'd1, 0, 1};
    vecs[8]  = '{1, 0, 0, 0, 32'h00, 32'hAA, 9'd0, 0, 1};
    vecs[9]  = '{1, 0, 0, 1, 32'h00, 32'h00, 9'd0, 0, 1};
    vecs[10] = '{0, 0, 0, 1, 32'h00, 32'h00, 9'd0, 0, 0};
    vecs[11] = '{0, 1, 0, 0, 32'h55, 32'h00, 9'd1, 0, 0};
    vecs[12] = '{1, 0, 0, 0, 32'h00, 32'h55, 9'd0, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 32'h00, 32'h55, 9'd0, 0, 0};
    vecs[14] = '{0, 1, 0, 0, 32'h66, 32'h55, 9'd1, 0, 0};
    vecs[15] = '{1, 1, 1, 0, 32'h77, 32'h55, 9'd0, 0, 0};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].fl, vecs[i].clr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_rd_data);
      checkOutput($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].exp_level));
      checkOutput($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      checkOutput($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].exp_udf));
    end

    // Fill to the brim, overflow, then a simultaneous read/write while full.
    for (int i = 0; i < 256; i++)
      applyStimulus(0, 1, 0, 0, 32'(i));
    checkOutput("fill full",  32'(full),  32'd1);
    checkOutput("fill level", 32'(level), 32'd256);
    checkOutput("fill half",  32'(half_full), 32'd0);
    applyStimulus(0, 1, 0, 0, 32'hDEAD);
    checkOutput("ovf flag",  32'(overflow), 32'd1);
    checkOutput("ovf level", 32'(level),    32'd256);
    applyStimulus(0, 0, 0, 1, 32'h0);
    checkOutput("ovf clear", 32'(overflow), 32'd0);
    applyStimulus(1, 1, 0, 0, 32'd256);
    checkOutput("full rw rd_data",  rd_data,        32'd0);
    checkOutput("full rw level",    32'(level),     32'd256);
    checkOutput("full rw overflow", 32'(overflow),  32'd0);

    // Drain across the pointer wrap: 1..255 then the wrapped 256.
    for (int i = 1; i <= 256; i++) begin
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput($sformatf("drain %0d", i), rd_data, 32'(i));
    end
    checkOutput("drain empty", 32'(empty), 32'd1);
    checkOutput("drain udf",   32'(underflow), 32'd0);

    // half_full threshold.
    for (int i = 0; i < 129; i++)
      applyStimulus(0, 1, 0, 0, 32'(i + 1000));
    checkOutput("129 level", 32'(level),     32'd129);
    checkOutput("129 half",  32'(half_full), 32'd0);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("128 level",   32'(level),     32'd128);
    checkOutput("128 half",    32'(half_full), 32'd1);
    checkOutput("128 rd_data", rd_data,        32'd1000);

    // Flush with a concurrent write, then count empty reads.
    applyStimulus(0, 1, 1, 0, 32'hBEEF);
    checkOutput("flush level", 32'(level), 32'd0);
    checkOutput("flush empty", 32'(empty), 32'd1);
    checkOutput("flush rd_data", rd_data, 32'd1000);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("empty reads udf", 32'(underflow), 32'd1);
    checkOutput("empty reads rd_data", rd_data, 32'h0);
`ifdef UNDERFLOW_CNT_EN
    checkOutput("udf_cnt 3", 32'(underflow_cnt), 32'd3);
`else
    checkOutput("udf_cnt tied", 32'(underflow_cnt), 32'd0);
`endif
    applyStimulus(0, 0, 0, 1, 32'h0);
    checkOutput("clr udf_cnt", 32'(underflow_cnt), 32'd0);
    checkOutput("clr udf",     32'(underflow),     32'd0);

    // Reset mid-burst, asserted together with flush and traffic.
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 0, 0, 32'(i + 50));
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("pre-reset rd_data", rd_data, 32'd50);
    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("pre-reset udf", 32'(underflow), 32'd1);
    applyStimulus(0, 1, 0, 0, 32'd77);
    Bus2IP_Reset = 1'b1;
    applyStimulus(1, 1, 1, 0, 32'd88);
    Bus2IP_Reset = 1'b0;
    checkOutput("mid reset level",   32'(level),     32'd0);
    checkOutput("mid reset rd_data", rd_data,        32'h0);
    checkOutput("mid reset udf",     32'(underflow), 32'd0);
    checkOutput("mid reset empty",   32'(empty),     32'd1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
